// File: rtl/multisim_rw_pkg.sv
// Shared types and command-field layout for the multisim read/write servers.
package multisim_rw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2,
    ST_RSP    = 2'd3
  } state_e;

  // Command word layout: [0]=rwb, [DATA_W +: DATA_W]=addr, [2*DATA_W +: DATA_W]=wdata
  localparam int unsigned RWB_BIT = 0;

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned wdata_lsb(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  function automatic int unsigned cmd_w(input int unsigned data_w);
    return 3 * data_w;
  endfunction

endpackage

// File: rtl/multisim_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module multisim_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % N);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/multisim_rw_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ command/response
// channels, with a single transaction in flight.
module multisim_rw_mem_arbiter
  import multisim_rw_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            cmd_vld,
  output logic [NUM_REQ-1:0]            cmd_rdy,
  input  logic [NUM_REQ*3*DATA_W-1:0]   cmd,
  output logic [NUM_REQ-1:0]            rsp_vld,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [NUM_REQ*DATA_W-1:0]     rsp,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned CMD_W     = cmd_w(DATA_W);
  localparam int unsigned ADDR_LSB  = addr_lsb(DATA_W);
  localparam int unsigned WDATA_LSB = wdata_lsb(DATA_W);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                rwb_q, rwb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;

  multisim_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i     (cmd_vld),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign busy = (state_q != ST_IDLE);

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    rwb_d     = rwb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;
    cmd_rdy   = '0;
    rsp_vld   = '0;
    rsp       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_rdy = gnt;
        // A grant implies the channel is valid, so the handshake completes here
        if (gnt_vld) begin
          owner_d = gnt_idx;
          rwb_d   = cmd[32'(gnt_idx) * CMD_W + RWB_BIT];
          addr_d  = cmd[32'(gnt_idx) * CMD_W + ADDR_LSB +: ADDR_W];
          wdata_d = cmd[32'(gnt_idx) * CMD_W + WDATA_LSB +: DATA_W];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = ~rwb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (rwb_q) begin
          state_d = ST_RDATA;
        end else begin
          rsp_d   = '0;
          state_d = ST_RSP;
        end
      end
      ST_RDATA: begin
        rsp_d   = mem_rdata;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_vld[owner_q]                     = 1'b1;
        rsp[32'(owner_q) * DATA_W +: DATA_W] = rsp_q;
        if (rsp_rdy[owner_q]) begin
          ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rwb_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rwb_q   <= rwb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_multisim_rw_mem_arbiter.sv
// Directed bench for multisim_rw_mem_arbiter with a 256x64 behavioural memory.
module tb_multisim_rw_mem_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 3 * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     cmd_vld, cmd_rdy, rsp_vld, rsp_rdy;
  logic [NR*CW-1:0]  cmd;
  logic [NR*DW-1:0]  rsp;
  logic              mem_en, mem_we, busy;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;

  logic [DW-1:0] mem_m   [256] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_m[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_m[mem_addr];
    end
  end

  multisim_rw_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd       (cmd),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp       (rsp),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int ch, input logic rwb, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata);
    cmd[ch*CW +: CW] = {wdata, addr, {(DW-1){1'b0}}, rwb};
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1) << i;
  endfunction

  function automatic logic [NR*DW-1:0] rsp_bus(input int g, input logic [DW-1:0] v);
    logic [NR*DW-1:0] b;
    b = '0;
    b[g*DW +: DW] = v;
    return b;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},    busy,    '0);
    chk({tag, ".cmd_rdy"}, cmd_rdy, '0);
    chk({tag, ".rsp_vld"}, rsp_vld, '0);
    chk({tag, ".rsp"},     rsp,     '0);
    chk({tag, ".mem_en"},  mem_en,  '0);
    chk({tag, ".mem_we"},  mem_we,  '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int               e, g, h, ptr_m;
  logic [NR-1:0]    mask;
  logic             trw   [NR];
  logic [DW-1:0]    taddr [NR];
  logic [DW-1:0]    twd   [NR];
  logic [DW-1:0]    exp_r;

  initial begin
    rst_n   = 1'b0;
    cmd_vld = '0;
    cmd     = '0;
    rsp_rdy = '1;
    tick();
    tick();
    chk_quiet("reset");
    rst_n = 1'b1;

    // Single write from ch0
    set_cmd(0, 1'b0, 64'h05, 64'hDEAD);
    cmd_vld = 4'b0001;
    #1;
    chk("wr.cmd_rdy", cmd_rdy, 4'b0001);
    chk("wr.busy_idle", busy, 1'b0);
    tick();
    cmd_vld = '0;
    chk("wr.mem_en", mem_en, 1'b1);
    chk("wr.mem_we", mem_we, 1'b1);
    chk("wr.mem_addr", mem_addr, 8'h05);
    chk("wr.mem_wdata", mem_wdata, 64'hDEAD);
    chk("wr.busy", busy, 1'b1);
    chk("wr.cmd_rdy_busy", cmd_rdy, '0);
    tick();
    chk("wr.rsp_vld", rsp_vld, 4'b0001);
    chk("wr.rsp", rsp, '0);
    tick();
    chk("wr.done_busy", busy, 1'b0);
    chk("wr.done_rsp_vld", rsp_vld, '0);
    ref_mem[5] = 64'hDEAD;
    chk("wr.mem_content", mem_m[5], ref_mem[5]);

    // Read back from ch1 with upper address bits set
    set_cmd(1, 1'b1, 64'h105, 64'h0);
    cmd_vld = 4'b0010;
    #1;
    chk("rd.cmd_rdy", cmd_rdy, 4'b0010);
    tick();
    cmd_vld = '0;
    chk("rd.mem_en", mem_en, 1'b1);
    chk("rd.mem_we", mem_we, 1'b0);
    chk("rd.mem_addr", mem_addr, 8'h05);
    tick();
    chk("rd.rdata_mem_en", mem_en, 1'b0);
    chk("rd.rdata_rsp_vld", rsp_vld, '0);
    chk("rd.rdata_busy", busy, 1'b1);
    tick();
    chk("rd.rsp_vld", rsp_vld, 4'b0010);
    chk("rd.rsp", rsp, rsp_bus(1, 64'hDEAD));
    tick();
    chk("rd.done_busy", busy, 1'b0);

    // Back-pressure on ch2 read while other channels wait
    set_cmd(2, 1'b1, 64'h05, 64'h0);
    cmd_vld = 4'b0100;
    rsp_rdy = 4'b1011;
    #1;
    chk("bp.cmd_rdy", cmd_rdy, 4'b0100);
    tick();
    set_cmd(0, 1'b0, 64'h07, 64'h77);
    set_cmd(3, 1'b0, 64'h08, 64'h88);
    cmd_vld = 4'b1001;
    chk("bp.mem_en", mem_en, 1'b1);
    chk("bp.mem_we", mem_we, 1'b0);
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp.hold_rsp_vld", rsp_vld, 4'b0100);
      chk("bp.hold_rsp", rsp, rsp_bus(2, 64'hDEAD));
      chk("bp.hold_cmd_rdy", cmd_rdy, '0);
      chk("bp.hold_mem_en", mem_en, 1'b0);
    end
    rsp_rdy = '1;
    cmd_vld = '0;
    #1;
    chk("bp.release_rsp_vld", rsp_vld, 4'b0100);
    tick();
    chk("bp.done_busy", busy, 1'b0);
    chk("bp.done_rsp_vld", rsp_vld, '0);

    // Reset while ch3 response is pending
    set_cmd(3, 1'b0, 64'h20, 64'hBEEF);
    cmd_vld = 4'b1000;
    rsp_rdy = 4'b0111;
    #1;
    chk("rst.cmd_rdy", cmd_rdy, 4'b1000);
    tick();
    cmd_vld = '0;
    chk("rst.mem_we", mem_we, 1'b1);
    chk("rst.mem_addr", mem_addr, 8'h20);
    tick();
    chk("rst.rsp_vld", rsp_vld, 4'b1000);
    rst_n = 1'b0;
    tick();
    chk_quiet("rst_rsp");
    ref_mem[8'h20] = 64'hBEEF;
    chk("rst.mem_content", mem_m[8'h20], ref_mem[8'h20]);
    rst_n   = 1'b1;
    rsp_rdy = '1;

    // Fairness: all channels request continuously; pointer restarts at 0
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 64'h30 + 64'(i), 64'h100 + 64'(i));
    cmd_vld = '1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      #1;
      chk("fair.cmd_rdy", cmd_rdy, onehot(e));
      tick();
      chk("fair.mem_addr", mem_addr, 8'(48 + e));
      chk("fair.mem_wdata", mem_wdata, 64'h100 + 64'(e));
      tick();
      chk("fair.rsp_vld", rsp_vld, onehot(e));
      chk("fair.rsp", rsp, '0);
      tick();
    end
    cmd_vld = '0;
    for (int i = 0; i < 4; i++) ref_mem[48 + i] = 64'h100 + 64'(i);

    // Random mixed traffic against the reference memory and pointer model
    ptr_m = 1;
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        trw[i]   = 1'($urandom_range(0, 1));
        taddr[i] = {32'($urandom()), 24'h0, 8'($urandom_range(0, 63))};
        twd[i]   = {32'($urandom()), 32'($urandom())};
        set_cmd(i, trw[i], taddr[i], twd[i]);
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && mask[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
      end
      h = $urandom_range(0, 2);
      cmd_vld = mask;
      rsp_rdy = (h > 0) ? ~onehot(g) : '1;
      #1;
      chk("rnd.cmd_rdy", cmd_rdy, onehot(g));
      tick();
      cmd_vld = '0;
      chk("rnd.mem_en", mem_en, 1'b1);
      chk("rnd.mem_we", mem_we, !trw[g]);
      chk("rnd.mem_addr", mem_addr, taddr[g][7:0]);
      if (trw[g]) begin
        exp_r = ref_mem[taddr[g][7:0]];
        tick();
      end else begin
        exp_r = '0;
        ref_mem[taddr[g][7:0]] = twd[g];
      end
      tick();
      for (int c = 0; c < h; c++) begin
        chk("rnd.hold_rsp_vld", rsp_vld, onehot(g));
        chk("rnd.hold_rsp", rsp, rsp_bus(g, exp_r));
        tick();
      end
      rsp_rdy = '1;
      chk("rnd.rsp_vld", rsp_vld, onehot(g));
      chk("rnd.rsp", rsp, rsp_bus(g, exp_r));
      tick();
      chk("rnd.done_busy", busy, 1'b0);
      ptr_m = (g + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
